// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one access per MEM_LATENCY+2 cycles.
// Optional ARB_ROUND_ROBIN_EN alternates grants on contention; otherwise data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  stall
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic win_dm_q, win_dm_d, win_we_q, win_we_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;
  logic if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic pick_dm;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm_q, last_dm_d;
  // On contention the side not granted last wins; lone requests win outright.
  assign pick_dm = dm_req & (~if_req | ~last_dm_q);
`else
  assign pick_dm = dm_req;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_dm_d    = win_dm_q;
    win_we_d    = win_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    busy_d      = busy_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dm_d   = last_dm_q;
`endif
    case (state_q)
      IDLE: if (if_req | dm_req) begin
        win_dm_d    = pick_dm;
        win_we_d    = pick_dm & dm_we;
        mem_en_d    = 1'b1;
        mem_we_d    = pick_dm & dm_we;
        mem_addr_d  = pick_dm ? dm_addr : if_addr;
        mem_wdata_d = pick_dm ? dm_wdata : mem_wdata_q;
        cnt_d       = 4'(MEM_LATENCY);
        busy_d      = 1'b1;
        state_d     = WAIT;
`ifdef ARB_ROUND_ROBIN_EN
        last_dm_d   = pick_dm;
`endif
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if_ready_d = ~win_dm_q;
          dm_ready_d = win_dm_q;
          if_rdata_d = win_dm_q ? if_rdata_q : mem_rdata;
          dm_rdata_d = (win_dm_q & ~win_we_q) ? mem_rdata : dm_rdata_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_dm_q    <= 1'b0;
      win_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_dm_q    <= win_dm_d;
      win_we_q    <= win_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q   <= last_dm_d;
`endif
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign busy      = busy_q;
  assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int L = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ready, dm_ready, mem_en, mem_we, busy, stall;
  int errors = 0, checks = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'h8C080004 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: read data is valid only L-1 cycles after the cycle mem_en was high.
  int since = 99;
  always @(posedge clock or posedge reset)
    if (reset) since <= 99;
    else since <= mem_en ? 1 : (since < 99 ? since + 1 : since);
  assign mem_rdata = (since == L - 1) ? mem_val(mem_addr) : 32'hBAD0BAD0;

  typedef struct {logic dm; logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;
  typedef struct {logic dm; logic [31:0] data;} resp_t;
  grant_t gq[$];
  resp_t rq[$];
  grant_t g;
  resp_t r;
  logic [31:0] dm_last_exp = '0;

  task automatic expect_acc(input logic dm, input logic we, input logic [31:0] a, input logic [31:0] wd);
    gq.push_back('{dm, we, a, wd});
    rq.push_back('{dm, dm ? (we ? dm_last_exp : mem_val(a)) : mem_val(a)});
    if (dm && !we) dm_last_exp = mem_val(a);
  endtask

  int cyc = 0, en_cyc = 0;
  logic en_prev = 1'b0, rdy_prev = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      en_prev = 1'b0;
      rdy_prev = 1'b0;
    end else begin
      cyc++;
      if (en_prev) check("en_pulse", {mem_en, mem_we}, 0);
      if (mem_en) begin
        if (gq.size() == 0) check("grant_unexpected", 1, 0);
        else begin
          g = gq.pop_front();
          check("mem_addr", mem_addr, g.addr);
          check("mem_we", mem_we, g.we);
          if (g.we) check("mem_wdata", mem_wdata, g.wdata);
          check("busy", busy, 1);
          en_cyc = cyc;
        end
      end
      if (if_ready | dm_ready) begin
        if (rq.size() == 0) check("ready_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          check("ready_side", {if_ready, dm_ready}, r.dm ? 2'b01 : 2'b10);
          check(r.dm ? "dm_rdata" : "if_rdata", r.dm ? dm_rdata : if_rdata, r.data);
          check("latency", cyc - en_cyc, L);
        end
      end
      if (rdy_prev) check("ready_pulse", {if_ready, dm_ready}, 0);
      en_prev = mem_en;
      rdy_prev = if_ready | dm_ready;
    end
  end

  // Returns at the negedge on which the chosen side's ready is seen.
  task automatic wait_rdy(input logic dm);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(dm ? dm_ready : if_ready) && n < 40);
    if (!(dm ? dm_ready : if_ready)) check(dm ? "dm_timeout" : "if_timeout", 0, 1);
  endtask

  task automatic fetch(input logic [31:0] a);
    expect_acc(1'b0, 1'b0, a, '0);
    if_req = 1'b1;
    if_addr = a;
    wait_rdy(1'b0);
    @(posedge clock); #1;
    if_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ctrl", {mem_en, mem_we, if_ready, dm_ready, busy, stall}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", if_rdata | dm_rdata | mem_wdata, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    // Single fetch at 0x10.
    expect_acc(1'b0, 1'b0, 32'h10, '0);
    if_req = 1'b1;
    if_addr = 32'h10;
    @(negedge clock);
    check("stall_req", stall, 1);
    wait_rdy(1'b0);
    check("stall_at_ready", stall, 0);
    @(posedge clock); #1;
    if_req = 1'b0;
    @(negedge clock);
    check("stall_idle", stall, 0);
    check("busy_idle", busy, 0);
    // Contention: data load wins, fetch follows two cycles after the ready pulse.
    expect_acc(1'b1, 1'b0, 32'h20, '0);
    expect_acc(1'b0, 1'b0, 32'h14, '0);
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 32'h14;
    dm_req = 1'b1; dm_addr = 32'h20; dm_we = 1'b0;
    fork
      begin
        wait_rdy(1'b1);
        check("stall_dm_done", stall, 1);
        @(posedge clock); #1;
        dm_req = 1'b0;
        @(negedge clock);
        check("gap_no_en", mem_en, 0);
        @(negedge clock);
        check("fetch_grant", mem_en, 1);
      end
      begin
        wait_rdy(1'b0);
        check("stall_if_done", stall, 0);
        @(posedge clock); #1;
        if_req = 1'b0;
      end
    join
    // Store leaves dm_rdata untouched.
    expect_acc(1'b1, 1'b1, 32'h24, 32'hDEADBEEF);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h24; dm_wdata = 32'hDEADBEEF;
    wait_rdy(1'b1);
    @(posedge clock); #1;
    dm_req = 1'b0; dm_we = 1'b0;
    fetch(32'h18);
    // Both sides held for four accesses.
`ifdef ARB_ROUND_ROBIN_EN
    expect_acc(1'b1, 1'b0, 32'h40, '0);
    expect_acc(1'b0, 1'b0, 32'h30, '0);
    expect_acc(1'b1, 1'b0, 32'h40, '0);
    expect_acc(1'b0, 1'b0, 32'h30, '0);
`else
    for (int i = 0; i < 4; i++) expect_acc(1'b1, 1'b0, 32'h40, '0);
`endif
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_addr = 32'h40;
    begin
      int seen = 0, n = 0;
      while (seen < 4 && n < 100) begin
        @(negedge clock);
        n++;
        if (if_ready | dm_ready) seen++;
      end
      check("hold_count", seen, 4);
    end
    @(posedge clock); #1;
    if_req = 1'b0; dm_req = 1'b0;
    // Reset while an access is waiting on memory.
    gq.push_back('{1'b0, 1'b0, 32'h50, 32'h0});
    if_req = 1'b1; if_addr = 32'h50;
    begin
      int n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!mem_en && n < 20);
      check("rst_test_grant", mem_en, 1);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    if_req = 1'b0;
    #1;
    check("mid_rst_ctrl", {mem_en, mem_we, if_ready, dm_ready, busy, stall}, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", if_rdata | dm_rdata | mem_wdata, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    fetch(32'h10);
    repeat (3) @(negedge clock);
    check("grant_q_empty", gq.size(), 0);
    check("resp_q_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified `Memory` between the instruction-fetch path and the load/store path of `DataPath`. The block accepts one request per side, picks a winner, sequences a multi-cycle memory access, returns read data with a one-cycle ready pulse, and raises `stall` for the pipeline while any requester is waiting. It sits between the CPU's fetch/MEM stages and `Memory`.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width
- `MEM_LATENCY`, 1, cycles from `mem_en` to valid `mem_rdata` (1..15)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_ready`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_rdata`  out  DATA_WIDTH  fetched word
- `if_ready`  out  1  one-cycle completion pulse, fetch
- `dm_req`  in  1  data request, held until `dm_ready`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  store data
- `dm_rdata`  out  DATA_WIDTH  load data
- `dm_ready`  out  1  one-cycle completion pulse, data
- `mem_en`  out  1  one-cycle access strobe to `Memory`
- `mem_we`  out  1  write strobe, coincident with `mem_en`
- `mem_addr`  out  ADDR_WIDTH  access address, stable for whole access
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_rdata`  in  DATA_WIDTH  read data from `Memory`
- `busy`  out  1  access in progress
- `stall`  out  1  combinational: `(if_req & ~if_ready) | (dm_req & ~dm_ready)`

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE; all registered outputs 0 (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, `if_ready`, `dm_ready`, `busy`).
- IDLE: if any request is sampled, choose a winner, latch its address/we/wdata into `mem_*`, pulse `mem_en` (and `mem_we` for stores) for one cycle, load 4-bit counter with `MEM_LATENCY`, set `busy`, go WAIT. No request: stay.
- WAIT: decrement counter each edge; at the edge where it reaches 0, capture `mem_rdata` into the winner's rdata register (loads/fetches only; stores leave `dm_rdata` unchanged), assert winner's ready, go RESP.
- RESP: ready high for exactly this cycle; requests ignored; next edge → IDLE, `busy` cleared.
- Default priority: data beats fetch on simultaneous requests.
- Requester that keeps `req` high after its ready pulse is treated as a new request (with current addr/data).
- Requests arriving during WAIT/RESP are held by the requester and sampled in IDLE.

## Timing
- Request sampled at edge E0 (IDLE): `mem_en` high during cycle after E0; rdata captured and ready high during cycle after edge E0+MEM_LATENCY; IDLE at E0+MEM_LATENCY+1; next grant earliest at E0+MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles.
- `mem_addr`/`mem_wdata` unchanged from E0 until next grant.
- Reset mid-access: outputs clear immediately, access abandoned, no ready pulse, round-robin pointer reset.
- `stall` has no registered delay; 0 when no request.

## Configuration
- `ARB_ROUND_ROBIN_EN`: defined → `last_grant` register (reset value = fetch); on simultaneous requests grant the side not granted last; single requests granted directly and update `last_grant`. Undefined → fixed data-over-fetch priority, no `last_grant` register.

## Test plan
- Reset, MEM_LATENCY=2, `if_req` addr 0x00000010, memory returns 0x8C080004 → `mem_en` one cycle after E0, `if_ready` one cycle after E2 with `if_rdata`=0x8C080004, `stall` low next cycle.
- Simultaneous `if_req` (0x14) and `dm_req` load (0x20), fixed priority → `mem_addr`=0x20 first, `dm_ready`; fetch granted at E0+MEM_LATENCY+2; `stall` high until `if_ready`.
- Store `dm_we`=1 addr 0x24 wdata 0xDEADBEEF → `mem_en`=`mem_we`=1 same single cycle, `mem_wdata`=0xDEADBEEF, `dm_ready` pulse, `dm_rdata` unchanged.
- `ARB_ROUND_ROBIN_EN` defined, both requests held continuously for four accesses → grant order data, fetch, data, fetch.
- Assert `reset` during WAIT → all outputs 0 immediately, no ready pulse; after release a fetch completes with normal latency.
